// File: rtl/button_pkg.sv
// Shared constants for the panel push-button front-end: hold-state encoding,
// button channel indices and 100 MHz timing constants.
`timescale 1ns/1ps
package button_pkg;

  // Hold FSM states; the fourth 2-bit encoding is unused and recovers to S_UP.
  typedef enum logic [1:0] {
    S_UP   = 2'd0,
    S_DOWN = 2'd1,
    S_LONG = 2'd2
  } hold_state_e;

  // Bit positions of the panel buttons on btn_raw.
  localparam int BTN_U = 0;
  localparam int BTN_C = 1;
  localparam int BTN_D = 2;

  // Timing constants at the 100 MHz system clock.
  localparam int CYC_10MS  = 1_000_000;
  localparam int CYC_200MS = 20_000_000;
  localparam int CYC_1S    = 100_000_000;

endpackage

// File: rtl/button_channel.sv
// One push-button channel: two-flop synchroniser, debounce counter and the
// hold FSM that produces press / release / long-press / auto-repeat ticks.
// The debounced level is the stable flop itself, so a clean raw edge shows
// up on level_o 2 + DEBOUNCE_CYCLES cycles later, together with its tick.
`timescale 1ns/1ps
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = CYC_10MS,
  parameter int LONG_CYCLES     = CYC_1S,
  parameter int REPEAT_CYCLES   = CYC_200MS
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HLD_W = $clog2(LONG_CYCLES);
  localparam int REP_W = $clog2(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]  DB_TERM  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HLD_W-1:0] HLD_TERM = HLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_TERM = REP_W'(REPEAT_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [HLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  hold_state_e      state_q, state_d;
  logic             press_q, release_q, long_q, repeat_q;
  logic             long_d, repeat_d;
  logic             db_term, rise, fall;

  // Two-flop synchroniser for the asynchronous pad.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive cycles of disagreement, flip on terminal count.
  always_comb begin
    db_term  = (sync2_q != stable_q) && (db_cnt_q == DB_TERM);
    rise     = db_term && sync2_q;
    fall     = db_term && !sync2_q;
    stable_d = db_term ? ~stable_q : stable_q;
    if ((sync2_q == stable_q) || db_term) begin
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Hold FSM next state; a stable fall always wins over long/repeat.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    case (state_q)
      S_UP: begin
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
        if (rise) begin
          state_d = S_DOWN;
        end
      end
      S_DOWN: begin
        if (fall) begin
          state_d    = S_UP;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end else if (hold_cnt_q == HLD_TERM) begin
          long_d     = 1'b1;
          state_d    = S_LONG;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_LONG: begin
        if (fall) begin
          state_d    = S_UP;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end else if (rep_cnt_q == REP_TERM) begin
          repeat_d  = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = S_UP;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
      end
    endcase
  end

  // State, counters and registered event ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q   <= 1'b0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      state_q    <= S_UP;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      stable_q   <= stable_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      state_q    <= state_d;
      press_q    <= rise;
      release_q  <= fall;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_event_conditioner.sv
// Panel push-button front-end: NUM_BTN independent conditioned channels plus
// a combined press tick that drives the click buzzer.
`timescale 1ns/1ps
module button_event_conditioner
  import button_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = CYC_10MS,
  parameter int LONG_CYCLES     = CYC_1S,
  parameter int REPEAT_CYCLES   = CYC_200MS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_tick,
  output logic [NUM_BTN-1:0] release_tick,
  output logic [NUM_BTN-1:0] long_tick,
  output logic [NUM_BTN-1:0] repeat_tick,
  output logic               any_press_tick
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .btn_raw_i (btn_raw[i]),
      .level_o   (btn_level[i]),
      .press_o   (press_tick[i]),
      .release_o (release_tick[i]),
      .long_o    (long_tick[i]),
      .repeat_o  (repeat_tick[i])
    );
  end

  // Press ticks are already registered, so the OR is a clean 1-cycle pulse.
  assign any_press_tick = |press_tick;

endmodule

// File: tb/tb_button_event_conditioner.sv
// Directed bench for button_event_conditioner with short debounce/hold timing.
`timescale 1ns/1ps
module tb_button_event_conditioner;

  localparam int NB = 3;
  localparam int DB = 4;
  localparam int LG = 20;
  localparam int RP = 8;
  localparam int LAT = 2 + DB;

  logic          clk;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level, press_tick, release_tick, long_tick, repeat_tick;
  logic          any_press_tick;

  int checks = 0;
  int errors = 0;

  button_event_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_raw        (btn_raw),
    .btn_level      (btn_level),
    .press_tick     (press_tick),
    .release_tick   (release_tick),
    .long_tick      (long_tick),
    .repeat_tick    (repeat_tick),
    .any_press_tick (any_press_tick)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    btn_raw = '0;
    repeat (3) tick();
    if ({btn_level, press_tick, release_tick, long_tick, repeat_tick, any_press_tick} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0000",
               {btn_level, press_tick, release_tick, long_tick, repeat_tick, any_press_tick});
    end
    checks++;
    reset = 1'b0;
    tick();
    if ({btn_level, press_tick, release_tick, long_tick, repeat_tick, any_press_tick} !== 16'h0) begin
      errors++;
      $display("FAIL post_reset_outputs: got %h expected 0000",
               {btn_level, press_tick, release_tick, long_tick, repeat_tick, any_press_tick});
    end
    checks++;
    repeat (3) tick();
  endtask

  task automatic test_clean_press();
    btn_raw[1] = 1'b1;
    for (int c = 1; c <= LAT; c++) begin
      tick();
      if (press_tick !== ((c == LAT) ? 3'b010 : 3'b000)) begin
        errors++;
        $display("FAIL clean_press c=%0d: got %b expected %b", c, press_tick, (c == LAT) ? 3'b010 : 3'b000);
      end
      checks++;
      if (btn_level !== ((c == LAT) ? 3'b010 : 3'b000)) begin
        errors++;
        $display("FAIL clean_level c=%0d: got %b", c, btn_level);
      end
      checks++;
      if (any_press_tick !== (c == LAT)) begin
        errors++;
        $display("FAIL clean_any c=%0d: got %b expected %b", c, any_press_tick, c == LAT);
      end
      checks++;
    end
    for (int c = LAT + 1; c <= 10; c++) begin
      tick();
      if ((press_tick | long_tick | any_press_tick) !== 3'b000) begin
        errors++;
        $display("FAIL clean_held c=%0d: press %b long %b any %b", c, press_tick, long_tick, any_press_tick);
      end
      checks++;
    end
    btn_raw[1] = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      tick();
      if (release_tick !== ((c == LAT) ? 3'b010 : 3'b000)) begin
        errors++;
        $display("FAIL clean_release c=%0d: got %b", c, release_tick);
      end
      checks++;
      if (btn_level !== ((c == LAT) ? 3'b000 : 3'b010)) begin
        errors++;
        $display("FAIL clean_rel_level c=%0d: got %b", c, btn_level);
      end
      checks++;
    end
    for (int c = 0; c < 25; c++) begin
      tick();
      if ((long_tick | release_tick | repeat_tick) !== 3'b000) begin
        errors++;
        $display("FAIL clean_after c=%0d: long %b rel %b rep %b", c, long_tick, release_tick, repeat_tick);
      end
      checks++;
    end
  endtask

  task automatic test_bounce();
    for (int b = 0; b < 3; b++) begin
      btn_raw[0] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (c == 3) btn_raw[0] = 1'b0;
        tick();
        if ((press_tick | btn_level) !== 3'b000) begin
          errors++;
          $display("FAIL bounce_quiet b=%0d c=%0d: press %b level %b", b, c, press_tick, btn_level);
        end
        checks++;
      end
    end
    btn_raw[0] = 1'b1;
    for (int c = 1; c <= LAT + 3; c++) begin
      tick();
      if (press_tick !== ((c == LAT) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL bounce_press c=%0d: got %b expected %b", c, press_tick, (c == LAT) ? 3'b001 : 3'b000);
      end
      checks++;
    end
    btn_raw[0] = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      tick();
      if (release_tick !== ((c == LAT) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL bounce_release c=%0d: got %b", c, release_tick);
      end
      checks++;
    end
    repeat (4) tick();
  endtask

  task automatic test_long_repeat();
    logic exp_long, exp_rep;
    btn_raw[2] = 1'b1;
    repeat (LAT) tick();
    if (press_tick !== 3'b100) begin
      errors++;
      $display("FAIL long_press: got %b expected 100", press_tick);
    end
    checks++;
    for (int c = 1; c <= 60; c++) begin
      tick();
      exp_long = (c == LG);
      exp_rep  = (c > LG) && (((c - LG) % RP) == 0);
      if (long_tick !== {exp_long, 2'b00}) begin
        errors++;
        $display("FAIL long_tick c=%0d: got %b expected %b", c, long_tick, {exp_long, 2'b00});
      end
      checks++;
      if (repeat_tick !== {exp_rep, 2'b00}) begin
        errors++;
        $display("FAIL repeat_tick c=%0d: got %b expected %b", c, repeat_tick, {exp_rep, 2'b00});
      end
      checks++;
    end
    btn_raw[2] = 1'b0;
    for (int c = 1; c <= LAT + 12; c++) begin
      tick();
      if (release_tick !== ((c == LAT) ? 3'b100 : 3'b000)) begin
        errors++;
        $display("FAIL long_release c=%0d: got %b", c, release_tick);
      end
      checks++;
      if ((repeat_tick | long_tick) !== 3'b000) begin
        errors++;
        $display("FAIL long_no_repeat c=%0d: rep %b long %b", c, repeat_tick, long_tick);
      end
      checks++;
    end
  endtask

  task automatic test_release_priority();
    btn_raw[1] = 1'b1;
    repeat (LAT) tick();
    if (press_tick !== 3'b010) begin
      errors++;
      $display("FAIL prio_press: got %b expected 010", press_tick);
    end
    checks++;
    // Raw fall lands LAT cycles before the long-press terminal cycle.
    for (int c = 1; c <= 40; c++) begin
      if (c == LG - LAT + 1) btn_raw[1] = 1'b0;
      tick();
      if (long_tick !== 3'b000 || repeat_tick !== 3'b000) begin
        errors++;
        $display("FAIL prio_no_long c=%0d: long %b rep %b", c, long_tick, repeat_tick);
      end
      checks++;
      if (release_tick !== ((c == LG) ? 3'b010 : 3'b000)) begin
        errors++;
        $display("FAIL prio_release c=%0d: got %b", c, release_tick);
      end
      checks++;
    end
  endtask

  task automatic test_simultaneous();
    btn_raw = 3'b111;
    repeat (LAT) tick();
    if (press_tick !== 3'b111) begin
      errors++;
      $display("FAIL simul_press: got %b expected 111", press_tick);
    end
    checks++;
    if (any_press_tick !== 1'b1) begin
      errors++;
      $display("FAIL simul_any: got %b expected 1", any_press_tick);
    end
    checks++;
    tick();
    if (press_tick !== 3'b000 || any_press_tick !== 1'b0) begin
      errors++;
      $display("FAIL simul_pulse_width: press %b any %b expected 000 0", press_tick, any_press_tick);
    end
    checks++;
    btn_raw = 3'b000;
    repeat (LAT - 1) tick();
    repeat (1) tick();
    if (release_tick !== 3'b111) begin
      errors++;
      $display("FAIL simul_release: got %b expected 111", release_tick);
    end
    checks++;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_hold();
    btn_raw[0] = 1'b1;
    repeat (LAT + LG + 3) tick();
    if (btn_level !== 3'b001) begin
      errors++;
      $display("FAIL midhold_level: got %b expected 001", btn_level);
    end
    checks++;
    reset = 1'b1;
    #1;
    if ({btn_level, press_tick, release_tick, long_tick, repeat_tick, any_press_tick} !== 16'h0) begin
      errors++;
      $display("FAIL midhold_async_clear: got %h expected 0000",
               {btn_level, press_tick, release_tick, long_tick, repeat_tick, any_press_tick});
    end
    checks++;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (release_tick !== 3'b000 || btn_level !== 3'b000) begin
        errors++;
        $display("FAIL midhold_in_reset c=%0d: rel %b level %b", c, release_tick, btn_level);
      end
      checks++;
    end
    reset = 1'b0;
    for (int c = 1; c <= LAT + 2; c++) begin
      tick();
      if (press_tick !== ((c == LAT) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL midhold_repress c=%0d: got %b expected %b", c, press_tick, (c == LAT) ? 3'b001 : 3'b000);
      end
      checks++;
      if (release_tick !== 3'b000) begin
        errors++;
        $display("FAIL midhold_no_release c=%0d: got %b", c, release_tick);
      end
      checks++;
    end
    btn_raw[0] = 1'b0;
    repeat (LAT + 2) tick();
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_release_priority();
    test_simultaneous();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_conditioner.md
Name: button_event_conditioner

Overview:
- Front-end for the panel push-buttons (btnU/btnC/btnD). Produces the clean, single-cycle button events that the buzzer controller, stopwatch and minute/second FSMs consume.
- Per channel it synchronises the raw pad input, debounces it, and emits press and release pulses.
- It also detects a long press and then generates auto-repeat pulses while the button stays held.
- Clock is the 100 MHz system clock.

Parameters:
- NUM_BTN, 3: number of independent button channels (bit0=U, bit1=C, bit2=D).
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles (10 ms) required to accept a level change; must be >= 2.
- LONG_CYCLES, 100_000_000: cycles (1 s) from accepted press to the long-press event; must be >= 2.
- REPEAT_CYCLES, 20_000_000: cycles (200 ms) between auto-repeat events after a long press; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_raw  input  NUM_BTN  raw asynchronous button pads, active-high (1 = pressed).
- btn_level  output  NUM_BTN  debounced level per channel.
- press_tick  output  NUM_BTN  1-cycle pulse on an accepted press.
- release_tick  output  NUM_BTN  1-cycle pulse on an accepted release.
- long_tick  output  NUM_BTN  1-cycle pulse when a press has lasted LONG_CYCLES.
- repeat_tick  output  NUM_BTN  1-cycle auto-repeat pulse while held past long press.
- any_press_tick  output  1  OR of all press_tick bits; drives the click buzzer.

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk.
  - All sync flops, debounce counters, hold/repeat counters and stable levels clear to 0.
  - All FSMs go to S_UP.
  - All outputs are 0 during reset and in the first cycle after it.
- Synchroniser: two-flop synchroniser per channel, giving sync_n.
- Debounce:
  - Counter clears whenever sync_n == stable_n.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 with sync_n still != stable_n, stable_n toggles on the next edge and the counter clears.
  - Any glitch back to the old value before that point clears the counter.
  - Latency from a clean raw edge to the btn_level change is 2 + DEBOUNCE_CYCLES cycles.
- btn_level = stable_n, registered.
- press_tick and release_tick are asserted in the same cycle that btn_level changes (rise and fall respectively). Both are registered, never combinational.
- Per-channel hold FSM:
  - S_UP: on stable rise, go to S_DOWN and clear hold_cnt.
  - S_DOWN: hold_cnt increments each cycle. At hold_cnt == LONG_CYCLES-1, assert long_tick for 1 cycle, go to S_LONG and clear rep_cnt. long_tick therefore follows press_tick by exactly LONG_CYCLES cycles.
  - S_LONG: rep_cnt increments each cycle. At rep_cnt == REPEAT_CYCLES-1, assert repeat_tick for 1 cycle and wrap rep_cnt to 0. The first repeat_tick comes REPEAT_CYCLES cycles after long_tick, then periodically.
  - Stable fall in any state: go to S_UP, assert release_tick, clear both counters.
  - Release priority: if the fall coincides with a long/repeat terminal count, only release_tick fires; long/repeat is suppressed.
  - Illegal or unused encoding: go to S_UP.
- Channels are fully independent. Simultaneous presses produce simultaneous press_tick bits, and any_press_tick is a single 1-cycle pulse.
- any_press_tick covers press only, not repeat.
- Button held through reset deassertion: it is debounced from level 0 as normal and press_tick fires 2 + DEBOUNCE_CYCLES cycles after reset falls.
- Reset mid-hold: everything aborts immediately; no release_tick is emitted.
- Counter widths: $clog2(param). Counters saturate-free by construction, since they always clear at their terminal value.
- Hold FSM at most one of press/release/long/repeat per channel per cycle.

Decomposition:
- Shared package button_pkg holds:
  - hold-state localparams S_UP / S_DOWN / S_LONG (2-bit);
  - button index constants BTN_U=0, BTN_C=1, BTN_D=2;
  - 100 MHz timing constants CYC_10MS, CYC_200MS, CYC_1S.
- Sub-module button_channel: synchroniser + debounce + hold FSM for one button. The top instantiates NUM_BTN copies in a generate loop and ORs the press ticks.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8):
- Clean press on bit1 held for 10 cycles, then released -> btn_level[1] rises and press_tick[1]/any_press_tick pulse 6 cycles after the raw edge; release_tick[1] pulses 6 cycles after the raw fall; no long_tick.
- Bounce: raw bit0 toggles high 3 cycles / low 1 cycle repeatedly, then stays high -> no tick during bouncing; exactly one press_tick[0], 6 cycles after the final stable rise.
- Hold bit2 for 60 cycles past press_tick -> long_tick[2] 20 cycles after press_tick, then repeat_tick[2] at +28, +36, +44, +52, +60; release_tick on release; no further repeats.
- Release timed so the debounced fall lands on the long-press terminal cycle -> release_tick only, no long_tick.
- All three raw inputs rise in the same cycle -> press_tick=3'b111 in one cycle and a single 1-cycle any_press_tick.
- Reset asserted mid-S_LONG with button held -> outputs are 0 immediately with no release_tick; after reset falls, press_tick fires 6 cycles later.
